// File: rtl/spi_cmd_rx.sv
// rtl/spi_cmd_rx.sv - oversampled SPI slave that assembles {brush,color,x,y} draw commands into a FIFO
// Optional coordinate clamping: define SPI_CMD_CLAMP_EN.
module spi_cmd_rx #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int COLOR_W     = 3,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               cs_n,
  output logic               sdo,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_brush,
  output logic [COLOR_W-1:0] cmd_color,
  output logic [X_W-1:0]     cmd_x,
  output logic [Y_W-1:0]     cmd_y,
  output logic               frame_err,
  output logic               overflow,
  input  logic               err_clr
);

  localparam int FIELD_W  = 1 + COLOR_W + X_W + Y_W;
  localparam int PKT_BITS = ((FIELD_W + 7) / 8) * 8;
  localparam int BC_W     = $clog2(PKT_BITS + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [BC_W-1:0]  BC_FULL  = BC_W'(PKT_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic               brush;
    logic [COLOR_W-1:0] color;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
  } cmd_t;

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (X_MAX < 0 || X_MAX >= (1 << X_W) || Y_MAX < 0 || Y_MAX >= (1 << Y_W)) begin : g_chk_max
    $error("X_MAX/Y_MAX must fit their coordinate widths");
  end

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  logic w_sck;
  logic w_sdi;
  logic w_cs;
  logic w_sck_rise;
  logic w_cs_rise;
  logic w_cs_fall;

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;
  assign w_cs_fall  = ~w_cs & r_cs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_cs_sync  <= '1;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b1;
    end else begin
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs;
    end
  end

  logic [BC_W-1:0]     r_bit_cnt;
  logic [PKT_BITS-1:0] r_shift;
  logic                r_frame_err;
  logic                w_done;

  assign w_done = (r_bit_cnt == BC_FULL);

  // A finished packet is handed to the FIFO before any cs_n edge is looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_done) begin
        r_bit_cnt <= '0;
      end else if (w_cs_rise || w_cs_fall) begin
        r_bit_cnt <= '0;
      end else if (w_sck_rise && !w_cs) begin
        r_shift   <= {r_shift[PKT_BITS-2:0], w_sdi};
        r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end

      if (w_cs_rise && !w_done && r_bit_cnt != '0) begin
        r_frame_err <= 1'b1;
      end else if (err_clr) begin
        r_frame_err <= 1'b0;
      end
    end
  end

  cmd_t w_raw;
  cmd_t w_push_data;

  assign w_raw = cmd_t'(r_shift[PKT_BITS-1 -: FIELD_W]);

`ifdef SPI_CMD_CLAMP_EN
  localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

  always_comb begin
    w_push_data = w_raw;
    if (w_raw.x > X_LIM) w_push_data.x = X_LIM;
    if (w_raw.y > Y_LIM) w_push_data.y = Y_LIM;
  end
`else
  assign w_push_data = w_raw;
`endif

  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_sdo;
  logic             r_overflow;
  cmd_t             r_head;

  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_drop;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_remain;
  logic [PTR_W-1:0] w_rd_next;
  cmd_t             w_head_next;

  assign w_pop        = r_valid && cmd_ready;
  assign w_full       = (r_count == CNT_FULL);
  assign w_push       = w_done && (!w_full || w_pop);
  assign w_drop       = w_done && w_full && !w_pop;
  assign w_remain     = r_count - CNT_W'(w_pop);
  assign w_count_next = w_remain + CNT_W'(w_push);
  assign w_rd_next    = r_rd_ptr + PTR_W'(w_pop);

  // The head register is what the consumer sees; refill it from the queue or
  // straight from the incoming packet when nothing older is waiting.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_remain == '0) w_head_next = w_push_data;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_sdo      <= 1'b0;
      r_overflow <= 1'b0;
      r_head     <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      r_sdo    <= (w_count_next == CNT_FULL);
      if (w_count_next != '0) r_head <= w_head_next;

      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign sdo       = r_sdo;
  assign cmd_valid = r_valid;
  assign cmd_brush = r_head.brush;
  assign cmd_color = r_head.color;
  assign cmd_x     = r_head.x;
  assign cmd_y     = r_head.y;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;

endmodule
